barrett_reducer: RTL and testbench

- Consumes the 2*mul_size-bit product from the upstream multiplier stage and returns that product reduced modulo m.
- Uses Barrett reduction with a precomputed constant mu = floor(2^(2*radix)/m).
- Sits directly downstream of the multiplier in the modular-multiply datapath.
- Fixed-latency, single-issue, multi-cycle. Output goes to the next modular stage or to the accumulator.

---
 rtl/barrett_reducer.sv | 164 ++++++++++++++++
 tb/tb_barrett_reducer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/barrett_reducer.sv
// Barrett modular reducer: reduces a 2*mul_size-bit product modulo m using the
// precomputed constant mu = floor(2^(2*radix)/m). Fixed five-clock latency,
// single request in flight; in_valid is ignored while busy.
//
// state | meaning
// IDLE  | waiting for a request; busy=0
// MUL1  | q2 = q1 * mu
// MUL2  | p = (q2 >> (radix+1)) * m, kept to radix+2 bits
// SUB   | r = x - p, kept to radix+2 bits
// CORR  | conditional subtraction of m or 2m, publish res/range_err
module barrett_reducer #(
    parameter int mul_size = 80,
    parameter int radix    = 78
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [2*mul_size-1:0]   x,
    input  logic [radix-1:0]        m,
    input  logic [radix:0]          mu,
    output logic                    busy,
    output logic                    out_valid,
    output logic [radix-1:0]        res,
    output logic                    range_err
);

    localparam int QW = radix + 1;        // q1 / q3 width
    localparam int PW = 2 * radix + 2;    // q2 width
    localparam int RW = radix + 2;        // width of the mod-2^(radix+2) remainder

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL1 = 3'd1,
        MUL2 = 3'd2,
        SUB  = 3'd3,
        CORR = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   x_q, x_d;            // only the low radix+2 bits of x matter after q1
    logic [radix-1:0] m_q, m_d;
    logic [radix:0]  mu_q, mu_d;
    logic [QW-1:0]   q1_q, q1_d;
    logic [PW-1:0]   q2_q, q2_d;
    logic [RW-1:0]   p_q, p_d;
    logic [RW-1:0]   r_q, r_d;
    logic            err_q, err_d;
    logic [radix-1:0] res_q, res_d;
    logic            out_valid_q, out_valid_d;
    logic            range_err_q, range_err_d;

    logic            x_hi_err;
    logic [QW-1:0]   q3;
    logic [RW-1:0]   m_ext;
    logic [RW-1:0]   m2_ext;

    // Any x bit above 2*radix-1 means the operand is out of Barrett range.
    if (mul_size > radix) begin : g_x_hi
        assign x_hi_err = |x[2*mul_size-1:2*radix];
    end else begin : g_x_no_hi
        assign x_hi_err = 1'b0;
    end

    assign q3     = QW'(q2_q >> (radix + 1));
    assign m_ext  = {2'b00, m_q};
    assign m2_ext = {1'b0, m_q, 1'b0};

    // Next-state and datapath: each state advances the reduction by one step.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        m_d         = m_q;
        mu_d        = mu_q;
        q1_d        = q1_q;
        q2_d        = q2_q;
        p_d         = p_q;
        r_d         = r_q;
        err_d       = err_q;
        res_d       = res_q;
        out_valid_d = 1'b0;
        range_err_d = range_err_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d     = RW'(x);
                    m_d     = m;
                    mu_d    = mu;
                    q1_d    = QW'(x >> (radix - 1));
                    err_d   = x_hi_err | ~m[radix-1];
                    state_d = MUL1;
                end
            end
            MUL1: begin
                q2_d    = PW'(q1_q) * PW'(mu_q);
                state_d = MUL2;
            end
            MUL2: begin
                p_d     = RW'(q3) * m_ext;
                state_d = SUB;
            end
            SUB: begin
                r_d     = x_q - p_q;
                state_d = CORR;
            end
            CORR: begin
                // r < 3m holds whenever the operand precondition is met, so at
                // most two subtractions of m are needed; result fits in radix bits.
                if (err_q) begin
                    res_d = '0;
                end else if (r_q >= m2_ext) begin
                    res_d = radix'(r_q - m2_ext);
                end else if (r_q >= m_ext) begin
                    res_d = radix'(r_q - m_ext);
                end else begin
                    res_d = radix'(r_q);
                end
                range_err_d = err_q;
                out_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset; reset aborts any request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            m_q         <= '0;
            mu_q        <= '0;
            q1_q        <= '0;
            q2_q        <= '0;
            p_q         <= '0;
            r_q         <= '0;
            err_q       <= 1'b0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            m_q         <= m_d;
            mu_q        <= mu_d;
            q1_q        <= q1_d;
            q2_q        <= q2_d;
            p_q         <= p_d;
            r_q         <= r_d;
            err_q       <= err_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
            range_err_q <= range_err_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign res       = res_q;
    assign range_err = range_err_q;

endmodule

// File: tb/tb_barrett_reducer.sv
// Scoreboard bench for barrett_reducer: a small instance (mul_size=10, radix=8)
// driven with directed vectors, and a default-parameter instance driven with
// reduced products whose golden remainder is computed here.
module tb_barrett_reducer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // small instance
    logic        iv_s;
    logic [19:0] x_s;
    logic [7:0]  m_s;
    logic [8:0]  mu_s;
    logic        busy_s, ov_s, err_s;
    logic [7:0]  res_s;

    // default-parameter instance
    logic         iv_b;
    logic [159:0] x_b;
    logic [77:0]  m_b;
    logic [78:0]  mu_b;
    logic         busy_b, ov_b, err_b;
    logic [77:0]  res_b;

    barrett_reducer #(.mul_size(10), .radix(8)) dut_s (
        .clk(clk), .rst(rst), .in_valid(iv_s), .x(x_s), .m(m_s), .mu(mu_s),
        .busy(busy_s), .out_valid(ov_s), .res(res_s), .range_err(err_s)
    );

    barrett_reducer dut_b (
        .clk(clk), .rst(rst), .in_valid(iv_b), .x(x_b), .m(m_b), .mu(mu_b),
        .busy(busy_b), .out_valid(ov_b), .res(res_b), .range_err(err_b)
    );

    typedef struct {
        logic [7:0] res;
        logic       err;
        int         acc;
    } exp_s_t;

    exp_s_t      q_s[$];
    logic [77:0] q_b[$];

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Small-instance monitor: result value, error flag, latency and busy state.
    always @(negedge clk) begin
        if (ov_s === 1'b1) begin
            if (q_s.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL small_unexpected_out: got out_valid res=%0d expected no result", res_s);
            end else begin
                exp_s_t e;
                e = q_s.pop_front();
                chk("small_res", 160'(res_s), 160'(e.res));
                chk("small_range_err", 160'(err_s), 160'(e.err));
                // Result registered at the fourth edge after the accept edge.
                chk("small_latency", 160'(cyc - e.acc), 160'(4));
                chk("small_busy_at_out", 160'(busy_s), 160'(0));
            end
        end
    end

    // Default-parameter monitor.
    always @(negedge clk) begin
        if (ov_b === 1'b1) begin
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL big_unexpected_out: got out_valid res=%0h expected no result", res_b);
            end else begin
                logic [77:0] e;
                e = q_b.pop_front();
                chk("big_res", 160'(res_b), 160'(e));
                chk("big_range_err", 160'(err_b), 160'(0));
            end
        end
    end

    task automatic issue_s(input logic [19:0] xv, input logic [7:0] mv, input logic [8:0] muv,
                           input logic [7:0] er, input logic ee);
        exp_s_t e;
        @(negedge clk);
        iv_s = 1'b1;
        x_s  = xv;
        m_s  = mv;
        mu_s = muv;
        e.res = er;
        e.err = ee;
        e.acc = cyc + 1;
        q_s.push_back(e);
        @(negedge clk);
        iv_s = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic issue_b(input logic [159:0] xv, input logic [77:0] mv, input logic [78:0] muv,
                           input logic [77:0] ev);
        @(negedge clk);
        iv_b = 1'b1;
        x_b  = xv;
        m_b  = mv;
        mu_b = muv;
        q_b.push_back(ev);
        @(negedge clk);
        iv_b = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [159:0] two156;
        logic [159:0] mw, muw, aw, bw, xw, ew;
        logic [95:0]  r96;
        int           wait_cnt;

        rst  = 1'b1;
        iv_s = 1'b0; x_s = '0; m_s = '0; mu_s = '0;
        iv_b = 1'b0; x_b = '0; m_b = '0; mu_b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", 160'(busy_s), 160'(0));
        chk("reset_out_valid", 160'(ov_s), 160'(0));
        chk("reset_res", 160'(res_s), 160'(0));
        chk("reset_range_err", 160'(err_s), 160'(0));
        chk("reset_big_busy", 160'(busy_b), 160'(0));

        // Directed vectors, m=251, mu=261.
        issue_s(20'd62500, 8'd251, 9'd261, 8'd1,   1'b0);
        issue_s(20'd0,     8'd251, 9'd261, 8'd0,   1'b0);
        issue_s(20'd251,   8'd251, 9'd261, 8'd0,   1'b0);
        issue_s(20'd63000, 8'd251, 9'd261, 8'd250, 1'b0);
        issue_s(20'd1000,  8'd251, 9'd261, 8'd247, 1'b0);

        // Precondition violations.
        issue_s(20'd62500, 8'd100, 9'd143, 8'd0,   1'b1);
        issue_s(20'd65536, 8'd251, 9'd261, 8'd0,   1'b1);

        // in_valid held high: accepts land every 5 clocks; x differs in between.
        @(negedge clk);
        for (int k = 0; k < 15; k++) begin
            iv_s = 1'b1;
            m_s  = 8'd251;
            mu_s = 9'd261;
            if (k % 5 == 0) begin
                exp_s_t e;
                x_s   = 20'd62500;
                e.res = 8'd1;
                e.err = 1'b0;
                e.acc = cyc + 1;
                q_s.push_back(e);
            end else begin
                x_s = (k % 2 == 1) ? 20'd1234 : 20'd63000;
            end
            @(negedge clk);
        end
        iv_s = 1'b0;
        repeat (6) @(negedge clk);

        // Reset at the third edge of a request: that request must never complete.
        iv_s = 1'b1; x_s = 20'd62500; m_s = 8'd251; mu_s = 9'd261;
        @(negedge clk);
        iv_s = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 160'(busy_s), 160'(0));
        chk("abort_res", 160'(res_s), 160'(0));
        chk("abort_out_valid", 160'(ov_s), 160'(0));
        repeat (8) @(negedge clk);
        issue_s(20'd300, 8'd251, 9'd261, 8'd49, 1'b0);

        // Default parameters: 78-bit odd moduli with MSB set, x = a*b with a,b < m.
        two156 = 160'd1 << 156;
        for (int n = 0; n < 1000; n++) begin
            r96 = {$urandom, $urandom, $urandom};
            mw  = {82'd0, 1'b1, r96[75:0], 1'b1};
            muw = two156 / mw;
            r96 = {$urandom, $urandom, $urandom};
            aw  = {64'd0, r96} % mw;
            r96 = {$urandom, $urandom, $urandom};
            bw  = {64'd0, r96} % mw;
            if (n == 0) begin
                aw = mw - 160'd1;
                bw = mw - 160'd1;
            end
            xw = aw * bw;
            ew = xw % mw;
            issue_b(xw, mw[77:0], muw[78:0], ew[77:0]);
        end

        wait_cnt = 0;
        while ((q_s.size() != 0 || q_b.size() != 0) && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        checks++;
        if (q_s.size() != 0 || q_b.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending results expected 0", q_s.size() + q_b.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
